// File: rtl/seg7_scan_capture_pkg.sv
// Shared constants for the 7-segment scan monitor: decode table, select helpers
// and the digit-acceptance FSM encoding.
package seg7_scan_capture_pkg;

  localparam int SEG_DIGITS = 8;
  localparam logic [7:0] SEL_BLANK = 8'hFF;

  // Active-low g..a patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_STABLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  function automatic logic sel_legal(input logic [7:0] sel);
    return (sel != SEL_BLANK) && ($countones(~sel) == 1);
  endfunction

  function automatic logic [2:0] sel_index(input logic [7:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < SEG_DIGITS; i++) begin
      if (!sel[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_scan_capture_decode.sv
// Combinational segment-to-nibble decoder; valid is low for patterns outside the table.
module seg7_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Monitors a multiplexed 7-segment bus, accepts stable digits, and publishes
// each complete eight-digit frame as a 32-bit word with decimal-point flags.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [7:0]  seg_in,
  input  logic [7:0]  sel_in,
  output logic [31:0] data_out,
  output logic [7:0]  dp_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        changed,
  output logic        timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [7:0]    seg_q, sel_q, seg_p, sel_p;
  state_t        state, state_next;
  logic [7:0]    stable_cnt, stable_next;
  logic          accept;
  logic [2:0]    acc_idx;
  logic [TW-1:0] tcnt, tcnt_next;
  logic [7:0]    seen;
  logic          err;
  logic [31:0]   slot_data;
  logic [7:0]    slot_dp;
  logic          dec_valid;
  logic [3:0]    dec_nibble;
  logic          frame_done;
  logic          tick;
  logic          hit;

  seg7_decode u_decode (
    .seg    (seg_q[6:0]),
    .valid  (dec_valid),
    .nibble (dec_nibble)
  );

  // Registered copy plus one-cycle-older copy for the stability comparison.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEL_BLANK;
      sel_q <= SEL_BLANK;
      seg_p <= SEL_BLANK;
      sel_p <= SEL_BLANK;
    end else begin
      seg_q <= seg_in;
      sel_q <= sel_in;
      seg_p <= seg_q;
      sel_p <= sel_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      stable_cnt <= 8'd0;
    end else begin
      state      <= state_next;
      stable_cnt <= stable_next;
    end
  end

  always_comb begin
    state_next  = state;
    stable_next = stable_cnt;
    accept      = 1'b0;
    case (state)
      S_WAIT: begin
        if (sel_legal(sel_q)) begin
          state_next  = S_STABLE;
          stable_next = 8'd1;
        end
      end
      S_STABLE: begin
        if ((seg_q != seg_p) || (sel_q != sel_p) || !sel_legal(sel_q)) begin
          state_next  = S_WAIT;
          stable_next = 8'd0;
        end else begin
          stable_next = stable_cnt + 8'd1;
          if (stable_next == 8'(STABLE_CYC)) begin
            accept     = 1'b1;
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Parked until the scan moves on, so one slot is taken once per pass.
        if (sel_q != sel_p) begin
          state_next  = S_WAIT;
          stable_next = 8'd0;
        end
      end
      default: begin
        state_next  = S_WAIT;
        stable_next = 8'd0;
      end
    endcase
  end

  assign acc_idx    = sel_index(sel_q);
  assign frame_done = (seen == 8'hFF);
  assign tick       = (seen != 8'd0) && !accept && !frame_done;
  assign hit        = tick && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign tcnt_next  = (!tick || hit) ? '0 : tcnt + 1'b1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      seen      <= 8'd0;
      err       <= 1'b0;
      tcnt      <= '0;
      slot_data <= 32'd0;
      slot_dp   <= 8'd0;
    end else begin
      tcnt <= tcnt_next;
      if (accept) begin
        slot_data[{acc_idx, 2'b00} +: 4] <= dec_nibble;
        slot_dp[acc_idx]                 <= ~seg_q[7];
      end
      // An accept in the same cycle as a discard still lands in the fresh mask.
      seen <= ((frame_done || hit) ? 8'd0 : seen)
              | (accept ? (8'd1 << acc_idx) : 8'd0);
      err  <= ((frame_done || hit) ? 1'b0 : err) | (accept && !dec_valid);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= 32'd0;
      dp_out      <= 8'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      changed     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      changed     <= frame_done && (slot_data != data_out);
      if (frame_done) begin
        data_out  <= slot_data;
        dp_out    <= slot_dp;
        frame_err <= err;
        timeout   <= 1'b0;
      end else if (hit) begin
        timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: scans words onto the segment bus and
// checks captured frames, flags, timeout and mid-frame reset behaviour.
module tb_seg7_scan_capture;

  localparam int TO_CYC = 100;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [7:0]  seg_in;
  logic [7:0]  sel_in;
  logic [31:0] data_out;
  logic [7:0]  dp_out;
  logic        frame_valid;
  logic        frame_err;
  logic        changed;
  logic        timeout;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          fcount   = 0;
  int          last_cyc = 0;
  int          t_last   = 0;
  logic [31:0] last_data;
  logic [7:0]  last_dp;
  logic        last_err;
  logic        last_changed;

  seg7_scan_capture #(
    .STABLE_CYC  (4),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .sel_in      (sel_in),
    .data_out    (data_out),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .changed     (changed),
    .timeout     (timeout)
  );

  // Clock and cycle counter.
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Frame capture, sampled away from the active edge.
  always @(negedge clk_in) begin
    if (frame_valid) begin
      fcount       = fcount + 1;
      last_cyc     = cyc;
      last_data    = data_out;
      last_dp      = dp_out;
      last_err     = frame_err;
      last_changed = changed;
    end
  end

  task automatic blank(input int n);
    sel_in = 8'hFF;
    seg_in = 8'hFF;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic drive_digit(input int idx, input logic [6:0] pat, input logic dp, input int cycles);
    sel_in = ~(8'h01 << idx);
    seg_in = {~dp, pat};
    repeat (cycles) @(negedge clk_in);
  endtask

  // Digit 7 first; bad marks digits sent with an undecodable pattern.
  task automatic scan_word(input logic [31:0] val, input logic [7:0] dp, input int cycles,
                           input bit gaps, input logic [7:0] bad);
    logic [6:0] pat;
    for (int d = 7; d >= 0; d--) begin
      pat = bad[d] ? 7'h7F : seg_tab[val[d*4 +: 4]];
      if (d == 0) t_last = cyc;
      drive_digit(d, pat, dp[d], cycles);
      if (gaps) blank(2);
    end
    blank(8);
  endtask

  task automatic check_frame(input string name, input int f0, input logic [31:0] exp_data,
                             input logic [7:0] exp_dp, input logic exp_err, input logic exp_chg);
    n_checks++;
    if (fcount !== f0 + 1) begin
      n_fail++;
      $display("FAIL %s frame_count: got %0d expected %0d", name, fcount - f0, 1);
    end
    n_checks++;
    if (last_data !== exp_data) begin
      n_fail++;
      $display("FAIL %s data_out: got %h expected %h", name, last_data, exp_data);
    end
    n_checks++;
    if (last_dp !== exp_dp) begin
      n_fail++;
      $display("FAIL %s dp_out: got %h expected %h", name, last_dp, exp_dp);
    end
    n_checks++;
    if (last_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s frame_err: got %b expected %b", name, last_err, exp_err);
    end
    n_checks++;
    if (last_changed !== exp_chg) begin
      n_fail++;
      $display("FAIL %s changed: got %b expected %b", name, last_changed, exp_chg);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    sel_in = 8'hFF;
    seg_in = 8'hFF;
    repeat (3) @(negedge clk_in);
    n_checks++;
    if ({data_out, dp_out, frame_valid, frame_err, changed, timeout} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h dp=%h fv=%b err=%b chg=%b to=%b expected all 0",
               data_out, dp_out, frame_valid, frame_err, changed, timeout);
    end
    rst_n = 1'b1;
    blank(3);
  endtask

  task automatic test_basic();
    int f0;
    f0 = fcount;
    scan_word(32'h12345678, 8'h00, 6, 1'b0, 8'h00);
    check_frame("basic", f0, 32'h12345678, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (last_cyc - t_last !== 7) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected %0d", last_cyc - t_last, 7);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = fcount;
    scan_word(32'h12345678, 8'h00, 6, 1'b0, 8'h00);
    check_frame("repeat", f0, 32'h12345678, 8'h00, 1'b0, 1'b0);
    f0 = fcount;
    scan_word(32'h1234567A, 8'h00, 6, 1'b0, 8'h00);
    check_frame("newval", f0, 32'h1234567A, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_short_hold();
    int f0;
    f0 = fcount;
    scan_word(32'h55555555, 8'h00, 3, 1'b0, 8'h00);
    n_checks++;
    if (fcount !== f0) begin
      n_fail++;
      $display("FAIL short_hold_frames: got %0d expected %0d", fcount - f0, 0);
    end
    n_checks++;
    if (data_out !== 32'h1234567A) begin
      n_fail++;
      $display("FAIL short_hold_data: got %h expected %h", data_out, 32'h1234567A);
    end
    f0 = fcount;
    scan_word(32'h89ABCDEF, 8'h21, 6, 1'b1, 8'h00);
    check_frame("blank_gaps", f0, 32'h89ABCDEF, 8'h21, 1'b0, 1'b1);
  endtask

  task automatic test_undecodable();
    int f0;
    f0 = fcount;
    scan_word(32'hDEADBEEF, 8'h00, 6, 1'b0, 8'h08);
    check_frame("undecodable", f0, 32'hDEAD0EEF, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_timeout();
    int f0;
    f0 = fcount;
    for (int d = 7; d >= 3; d--) drive_digit(d, seg_tab[4'(d)], 1'b0, 6);
    blank(90);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got %b expected %b", timeout, 1'b0);
    end
    blank(15);
    n_checks++;
    if (timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_set: got %b expected %b", timeout, 1'b1);
    end
    n_checks++;
    if ({fcount - f0, data_out} !== {32'd0, 32'hDEAD0EEF}) begin
      n_fail++;
      $display("FAIL timeout_data: frames=%0d data=%h expected frames=0 data=%h",
               fcount - f0, data_out, 32'hDEAD0EEF);
    end
    f0 = fcount;
    scan_word(32'hCAFEF00D, 8'h00, 6, 1'b0, 8'h00);
    check_frame("after_timeout", f0, 32'hCAFEF00D, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b expected %b", timeout, 1'b0);
    end
  endtask

  task automatic test_reset_midframe();
    int f0;
    for (int d = 7; d >= 4; d--) drive_digit(d, seg_tab[9], 1'b1, 6);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    n_checks++;
    if ({data_out, dp_out, frame_valid, timeout} !== 42'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got data=%h dp=%h fv=%b to=%b expected all 0",
               data_out, dp_out, frame_valid, timeout);
    end
    rst_n = 1'b1;
    blank(3);
    f0 = fcount;
    scan_word(32'h0000FFFF, 8'h00, 6, 1'b0, 8'h00);
    check_frame("post_reset", f0, 32'h0000FFFF, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n  = 1'b0;
    sel_in = 8'hFF;
    seg_in = 8'hFF;
    @(negedge clk_in);
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_hold();
    test_undecodable();
    test_timeout();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
